// File: rtl/cpu_bus_master.sv
// Famicom CPU-bus initiator: free-running M2 with one request launched per cycle.
// Cycles with no pending request run as idle reads of $0000.
module cpu_bus_master #(
  parameter int unsigned M2_LOW_CLKS  = 9,
  parameter int unsigned M2_HIGH_CLKS = 9
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rw_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        m2_o,
  output logic        romsel_o,
  output logic        cpu_rw_o,
  output logic [14:0] cpu_addr_o,
  output logic [7:0]  cpu_data_out_o,
  output logic        cpu_data_oe_o,
  input  logic [7:0]  cpu_data_in_i,
  input  logic        irq_n_i,
  output logic        irq_sync_o,
  output logic [15:0] m2_cycles_o
);

  localparam logic [0:0] ST_LOW    = 1'b0;
  localparam logic [0:0] ST_HIGH   = 1'b1;
  localparam logic [7:0] LOW_LAST  = 8'(M2_LOW_CLKS - 1);
  localparam logic [7:0] HIGH_LAST = 8'(M2_HIGH_CLKS - 1);

  logic [0:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        pend_rw_q, pend_rw_d;
  logic [15:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_wdata_q, pend_wdata_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_rw_q, bus_rw_d;
  logic        bus_a15_q, bus_a15_d;
  logic [14:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        m2_q, m2_d;
  logic        romsel_q, romsel_d;
  logic        oe_q, oe_d;
  logic [7:0]  dout_q, dout_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic [15:0] m2_cycles_q, m2_cycles_d;
  logic        irq_meta_q, irq_sync2_q;
  logic        accept, rise, fall;

  assign req_ready_o = ~pend_q & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  assign rise        = (state_q == ST_LOW)  && (cnt_q == LOW_LAST);
  assign fall        = (state_q == ST_HIGH) && (cnt_q == HIGH_LAST);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 8'd1;
    pend_d       = pend_q;
    pend_rw_d    = pend_rw_q;
    pend_addr_d  = pend_addr_q;
    pend_wdata_d = pend_wdata_q;
    bus_req_d    = bus_req_q;
    bus_rw_d     = bus_rw_q;
    bus_a15_d    = bus_a15_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    m2_d         = m2_q;
    romsel_d     = romsel_q;
    oe_d         = oe_q;
    dout_d       = dout_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    m2_cycles_d  = m2_cycles_q;

    if (rise) begin
      state_d  = ST_HIGH;
      cnt_d    = 8'd0;
      m2_d     = 1'b1;
      romsel_d = ~bus_a15_q;
      if (!bus_rw_q) begin
        oe_d   = 1'b1;
        dout_d = bus_wdata_q;
      end
    end

    if (fall) begin
      state_d     = ST_LOW;
      cnt_d       = 8'd0;
      m2_d        = 1'b0;
      romsel_d    = 1'b1;
      oe_d        = 1'b0;
      m2_cycles_d = m2_cycles_q + 16'd1;
      if (bus_req_q && bus_rw_q) begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = cpu_data_in_i;
      end
      // Launch uses the slot as it stood before this edge.
      if (pend_q) begin
        pend_d      = 1'b0;
        bus_req_d   = 1'b1;
        bus_rw_d    = pend_rw_q;
        bus_a15_d   = pend_addr_q[15];
        bus_addr_d  = pend_addr_q[14:0];
        bus_wdata_d = pend_wdata_q;
      end else begin
        bus_req_d   = 1'b0;
        bus_rw_d    = 1'b1;
        bus_a15_d   = 1'b0;
        bus_addr_d  = 15'd0;
      end
    end

    if (accept) begin
      pend_d       = 1'b1;
      pend_rw_d    = req_rw_i;
      pend_addr_d  = req_addr_i;
      pend_wdata_d = req_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_LOW;
      cnt_q        <= 8'd0;
      pend_q       <= 1'b0;
      pend_rw_q    <= 1'b1;
      pend_addr_q  <= 16'd0;
      pend_wdata_q <= 8'd0;
      bus_req_q    <= 1'b0;
      bus_rw_q     <= 1'b1;
      bus_a15_q    <= 1'b0;
      bus_addr_q   <= 15'd0;
      bus_wdata_q  <= 8'd0;
      m2_q         <= 1'b0;
      romsel_q     <= 1'b1;
      oe_q         <= 1'b0;
      dout_q       <= 8'd0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= 8'd0;
      m2_cycles_q  <= 16'd0;
      irq_meta_q   <= 1'b1;
      irq_sync2_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_rw_q    <= pend_rw_d;
      pend_addr_q  <= pend_addr_d;
      pend_wdata_q <= pend_wdata_d;
      bus_req_q    <= bus_req_d;
      bus_rw_q     <= bus_rw_d;
      bus_a15_q    <= bus_a15_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      m2_q         <= m2_d;
      romsel_q     <= romsel_d;
      oe_q         <= oe_d;
      dout_q       <= dout_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      m2_cycles_q  <= m2_cycles_d;
      irq_meta_q   <= irq_n_i;
      irq_sync2_q  <= irq_meta_q;
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign m2_o           = m2_q;
  assign romsel_o       = romsel_q;
  assign cpu_rw_o       = bus_rw_q;
  assign cpu_addr_o     = bus_addr_q;
  assign cpu_data_out_o = dout_q;
  assign cpu_data_oe_o  = oe_q;
  assign irq_sync_o     = ~irq_sync2_q;
  assign m2_cycles_o    = m2_cycles_q;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Directed bench for cpu_bus_master at default timing (9/9); t counts clocks since reset release.
// The cartridge model answers reads in the HIGH phase with addr[7:0] ^ 0x3C.
module tb_cpu_bus_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b1;
  logic [15:0] req_addr = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        m2, romsel, cpu_rw, cpu_data_oe, irq_sync;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_data_out, cpu_data_in;
  logic        irq_n = 1'b1;
  logic [15:0] m2_cycles;

  int checks = 0;
  int failures = 0;
  int t = 0;
  int n_rsp, n_high, n_rise, n_rsl_low, n_rsl_bad, n_oe, n_oe_bad;
  logic       m2_prev = 1'b0;
  logic [7:0] rsp_log[$];
  int         rsp_at[$];

  always #5 clk = ~clk;

  assign cpu_data_in = (cpu_rw && m2) ? (cpu_addr[7:0] ^ 8'h3C) : 8'hFF;

  cpu_bus_master dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .m2_o(m2), .romsel_o(romsel), .cpu_rw_o(cpu_rw), .cpu_addr_o(cpu_addr),
    .cpu_data_out_o(cpu_data_out), .cpu_data_oe_o(cpu_data_oe),
    .cpu_data_in_i(cpu_data_in), .irq_n_i(irq_n), .irq_sync_o(irq_sync),
    .m2_cycles_o(m2_cycles)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_rsp = 0; n_high = 0; n_rise = 0; n_rsl_low = 0; n_rsl_bad = 0; n_oe = 0; n_oe_bad = 0;
    rsp_log.delete();
    rsp_at.delete();
  endtask

  task automatic step();
    @(negedge clk);
    t++;
    if (rsp_valid) begin
      n_rsp++;
      rsp_log.push_back(rsp_rdata);
      rsp_at.push_back(t);
    end
    if (m2) n_high++;
    if (m2 && !m2_prev) n_rise++;
    m2_prev = m2;
    if (!romsel) n_rsl_low++;
    if (!romsel && !m2) n_rsl_bad++;
    if (cpu_data_oe) n_oe++;
    if (cpu_data_oe && !(m2 && !cpu_rw)) n_oe_bad++;
  endtask

  task automatic step_to(input int target);
    while (t < target) step();
  endtask

  initial begin
    int bad, idx;
    logic acc;
    logic [14:0] a1, a2, a3;
    a1 = '0; a2 = '0; a3 = '0;
    clr();

    repeat (3) @(negedge clk);
    check("rst_m2", m2, 1'b0);
    check("rst_romsel", romsel, 1'b1);
    check("rst_rw", cpu_rw, 1'b1);
    check("rst_addr", cpu_addr, 15'h0);
    check("rst_oe", cpu_data_oe, 1'b0);
    check("rst_dout", cpu_data_out, 8'h00);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_irq_sync", irq_sync, 1'b0);
    check("rst_m2_cycles", m2_cycles, 16'h0);
    check("rst_ready", req_ready, 1'b0);
    rst = 1'b0;
    t = 0;

    // Idle running: period 18, high on clocks 9..17 of each period.
    clr();
    bad = 0;
    repeat (180) begin
      step();
      if (m2 !== ((t % 18) >= 9)) bad++;
    end
    check("idle_m2_pattern", bad, 0);
    check("idle_high_clks", n_high, 90);
    check("idle_rises", n_rise, 10);
    check("idle_romsel_low", n_rsl_low, 0);
    check("idle_rsp", n_rsp, 0);
    check("idle_m2_cycles", m2_cycles, 16'd10);

    // Write 0xA5 to $8000: accepted at 181, launched at 198, high 207..215.
    clr();
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h8000; req_wdata = 8'hA5;
    step();
    check("wr_ready_after_accept", req_ready, 1'b0);
    req_valid = 1'b0;
    step_to(197);
    check("wr_prev_cycle_idle_rw", cpu_rw, 1'b1);
    step_to(198);
    check("wr_launch_rw", cpu_rw, 1'b0);
    check("wr_launch_addr", cpu_addr, 15'h0000);
    check("wr_launch_m2", m2, 1'b0);
    check("wr_launch_oe", cpu_data_oe, 1'b0);
    step_to(207);
    check("wr_high_m2", m2, 1'b1);
    check("wr_high_romsel", romsel, 1'b0);
    check("wr_high_oe", cpu_data_oe, 1'b1);
    check("wr_high_dout", cpu_data_out, 8'hA5);
    step_to(216);
    check("wr_end_m2", m2, 1'b0);
    check("wr_end_romsel", romsel, 1'b1);
    check("wr_end_oe", cpu_data_oe, 1'b0);
    check("wr_end_dout_held", cpu_data_out, 8'hA5);
    check("wr_end_idle_rw", cpu_rw, 1'b1);
    check("wr_romsel_low_clks", n_rsl_low, 9);
    check("wr_romsel_outside_m2", n_rsl_bad, 0);
    check("wr_oe_clks", n_oe, 9);
    check("wr_oe_outside_high", n_oe_bad, 0);
    check("wr_no_rsp", n_rsp, 0);

    // Read $6000: launched at 234, high 243..251, response sampled at 252.
    clr();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h6000;
    step();
    req_valid = 1'b0;
    step_to(243);
    check("rd_high_m2", m2, 1'b1);
    check("rd_high_addr", cpu_addr, 15'h6000);
    check("rd_high_rw", cpu_rw, 1'b1);
    step_to(251);
    check("rd_no_early_rsp", n_rsp, 0);
    step_to(252);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_data", rsp_rdata, 8'h3C);
    step();
    check("rd_rsp_pulse_end", rsp_valid, 1'b0);
    check("rd_rdata_held", rsp_rdata, 8'h3C);
    check("rd_rsp_count", n_rsp, 1);
    check("rd_romsel_low", n_rsl_low, 0);

    // Back-to-back reads $8001..$8003 at t=253: launches at 270, 288, 306.
    clr();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8001;
    idx = 0;
    acc = req_ready;
    while (t < 330) begin
      step();
      if (acc) begin
        idx++;
        if (idx == 3) req_valid = 1'b0;
        else req_addr = 16'h8001 + 16'(idx);
      end
      acc = req_valid && req_ready;
      if (t == 279) a1 = cpu_addr;
      if (t == 297) a2 = cpu_addr;
      if (t == 315) a3 = cpu_addr;
    end
    check("b2b_accepted", idx, 3);
    check("b2b_addr1", a1, 15'h0001);
    check("b2b_addr2", a2, 15'h0002);
    check("b2b_addr3", a3, 15'h0003);
    check("b2b_rsp_count", n_rsp, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_rsp%0d_data", i), (i < rsp_log.size()) ? rsp_log[i] : 8'hxx,
            8'h3D + 8'(i));
      check($sformatf("b2b_rsp%0d_time", i), (i < rsp_at.size()) ? rsp_at[i] : -1,
            288 + 18 * i);
    end

    // Request accepted on the HIGH->LOW edge at 342: idle cycle first, launch at 360.
    clr();
    step_to(341);
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8004;
    step();
    check("edge_ready_after_accept", req_ready, 1'b0);
    check("edge_idle_addr", cpu_addr, 15'h0000);
    check("edge_idle_rw", cpu_rw, 1'b1);
    req_valid = 1'b0;
    step_to(351);
    check("edge_idle_m2", m2, 1'b1);
    check("edge_idle_romsel", romsel, 1'b1);
    step_to(360);
    check("edge_launch_addr", cpu_addr, 15'h0004);
    step_to(369);
    check("edge_high_romsel", romsel, 1'b0);
    step_to(378);
    check("edge_rsp_valid", rsp_valid, 1'b1);
    check("edge_rsp_data", rsp_rdata, 8'h38);

    // IRQ synchronizer: two-clock lag each way.
    irq_n = 1'b0;
    step();
    check("irq_lag1", irq_sync, 1'b0);
    step();
    check("irq_lag2", irq_sync, 1'b1);
    irq_n = 1'b1;
    step();
    check("irq_rel_lag1", irq_sync, 1'b1);
    step();
    check("irq_rel_lag2", irq_sync, 1'b0);

    // Reset during HIGH of a read of $8005 (launch 396, high 405..413).
    clr();
    req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h8005;
    step();
    req_valid = 1'b0;
    step_to(408);
    check("rstmid_pre_m2", m2, 1'b1);
    check("rstmid_pre_romsel", romsel, 1'b0);
    check("rstmid_pre_addr", cpu_addr, 15'h0005);
    rst = 1'b1;
    #1;
    check("rstmid_m2", m2, 1'b0);
    check("rstmid_romsel", romsel, 1'b1);
    check("rstmid_rsp_valid", rsp_valid, 1'b0);
    check("rstmid_ready", req_ready, 1'b0);
    check("rstmid_addr", cpu_addr, 15'h0000);
    check("rstmid_m2_cycles", m2_cycles, 16'h0);
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    check("rstmid_no_rsp", n_rsp, 0);
    check("rstmid_rdata", rsp_rdata, 8'h00);
    check("rstmid_after_cycles", m2_cycles, 16'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
